seq_player: RTL and testbench
=============================

SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 8: bits per sequence, at least 2.
REQ-002 SHALL have parameter NUM_SEQ, default 8: number of stored sequences, a power of two, at least 2.
REQ-003 SHALL have parameter TICK_DIV, default 4: clock cycles each bit is held, at least 1.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: request to begin playback, sampled only in IDLE.
REQ-007 SHALL have port index, input, $clog2(NUM_SEQ): sequence select, sampled with start.
REQ-008 SHALL have port loop, input, 1: repeat request, sampled at the end of each pass (see REQ-022).
REQ-009 SHALL have port bit_out, output, 1: current serial bit, MSB first.
REQ-010 SHALL have port busy, output, 1: high while a playback is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when playback ends.
REQ-012 SHALL have port cur_index, output, $clog2(NUM_SEQ): index latched for the current playback.

Function
REQ-013 SHALL use states IDLE, PLAY, DONE.
REQ-014 IDLE -> PLAY SHALL occur on the edge where start=1; in the same edge index SHALL be latched into cur_index and the selected word loaded into a shift register.
REQ-015 Latency: bit_out SHALL show the MSB of the selected sequence and busy SHALL be 1 starting the cycle after start is sampled.
REQ-016 Each bit SHALL be held exactly TICK_DIV cycles, using a tick counter that runs 0..TICK_DIV-1 and wraps.
REQ-017 A bit counter SHALL count 0..SEQ_LEN-1; the shift register SHALL shift left by one on each tick wrap.
REQ-018 One pass SHALL keep busy=1 for exactly SEQ_LEN*TICK_DIV cycles.
REQ-019 When the last bit's final tick ends and the pass completes, the FSM SHALL enter DONE; in DONE, done=1, busy=0 and bit_out=0 for one cycle, then the FSM SHALL return to IDLE.
REQ-020 start and index changes while in PLAY or DONE SHALL be ignored; changes to the ROM output SHALL NOT affect a playback in progress.
REQ-021 In IDLE, bit_out=0, busy=0, done=0, and cur_index SHALL hold its last latched value.

Reset
REQ-023 While rst=1, regardless of clk, the FSM SHALL be in IDLE and bit_out, busy, done, cur_index, all counters and the shift register SHALL be 0.
REQ-024 Reset asserted mid-playback SHALL abort the playback immediately, with no done pulse.
REQ-025 After rst deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-022 With SEQ_PLAYER_LOOP_EN defined: if loop=1 on the final cycle of a pass, the FSM SHALL reload the same cur_index word and stay in PLAY with no gap and no done pulse; if loop=0, it SHALL end per REQ-019.
REQ-026 Without SEQ_PLAYER_LOOP_EN: the loop port SHALL still be present but ignored, and every playback SHALL be a single pass.

Structure
REQ-027 A shared package seq_pkg SHALL hold the default constants SEQ_LEN_DEF=8 and NUM_SEQ_DEF=8, the state enum type, and the default table SEQ_TABLE_DEF: 11110111, 00000001, 10010101, 01010101, 10101011, 10111000, 10111011, 10111110 (entries 0 to 7).
REQ-028 One sub-module, seq_rom, SHALL be instantiated: a combinational table lookup parametrised by SEQ_LEN, NUM_SEQ and a table parameter that defaults to SEQ_TABLE_DEF.
REQ-029 All widths SHALL be derived from the parameters, with no hard-coded 8s.

Verification
REQ-030 Defaults, index=0, one-cycle start: bit_out SHALL be 1,1,1,1,0,1,1,1, each held 4 cycles; busy SHALL be high for exactly 32 cycles; done SHALL pulse in cycle 33.
REQ-031 Defaults, index=1: bit_out SHALL be 0 for 28 cycles, then 1 for 4 cycles, then done SHALL pulse.
REQ-032 start pulsed again at cycle 10 of a playback of index 3, with index=5: the output SHALL remain 01010101, and cur_index SHALL stay 3.
REQ-033 rst asserted at cycle 13 of a playback: bit_out, busy and done SHALL go to 0 asynchronously; no done pulse SHALL occur; a start 1 cycle after release SHALL play normally.
REQ-034 LOOP_EN defined, index=4, loop held 1 for 2 passes and then dropped: the bench SHALL see 3 back-to-back copies of 10101011, 96 busy cycles and a single done pulse.
REQ-035 TICK_DIV=1, SEQ_LEN=4, NUM_SEQ=2: the bench SHALL see one bit per cycle, busy for 4 cycles, and done on the 5th cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants, state type and default pattern table for the sequence player.
// Used by seq_rom and seq_player.
package seq_pkg;

    localparam int SEQ_LEN_DEF = 8;
    localparam int NUM_SEQ_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Entry 0 sits in the least-significant slice, entry 7 in the most-significant.
    localparam logic [NUM_SEQ_DEF-1:0][SEQ_LEN_DEF-1:0] SEQ_TABLE_DEF = {
        8'b10111110, 8'b10111011, 8'b10111000, 8'b10101011,
        8'b01010101, 8'b10010101, 8'b00000001, 8'b11110111
    };

    // Counter width that stays at least one bit for a range of a single value.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_rom.sv
// Combinational pattern table: returns the SEQ_LEN-bit word stored at addr.
module seq_rom
    import seq_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int NUM_SEQ = NUM_SEQ_DEF,
    parameter logic [NUM_SEQ-1:0][SEQ_LEN-1:0] TABLE = (NUM_SEQ*SEQ_LEN)'(SEQ_TABLE_DEF)
) (
    input  logic [$clog2(NUM_SEQ)-1:0] addr,
    output logic [SEQ_LEN-1:0]         data
);

    assign data = TABLE[addr];

endmodule

// File: rtl/seq_player.sv
// Serial pattern player: loads a table word on start and shifts it out MSB first,
// each bit held TICK_DIV cycles. Optional repeat playback under SEQ_PLAYER_LOOP_EN.
//
// state | meaning
// IDLE  | waiting for start; outputs low, cur_index holds last latched value
// PLAY  | shifting the loaded word out, busy high
// DONE  | one-cycle done pulse, then back to IDLE
module seq_player
    import seq_pkg::*;
#(
    parameter int SEQ_LEN  = SEQ_LEN_DEF,
    parameter int NUM_SEQ  = NUM_SEQ_DEF,
    parameter int TICK_DIV = 4,
    parameter logic [NUM_SEQ-1:0][SEQ_LEN-1:0] SEQ_TABLE = (NUM_SEQ*SEQ_LEN)'(SEQ_TABLE_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(NUM_SEQ)-1:0] index,
    input  logic                       loop,
    output logic                       bit_out,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_SEQ)-1:0] cur_index
);

    localparam int IW = $clog2(NUM_SEQ);
    localparam int TW = cnt_width(TICK_DIV);
    localparam int BW = cnt_width(SEQ_LEN);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SEQ_LEN - 1);

    seq_state_e         state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [SEQ_LEN-1:0] shreg_q, shreg_d;
    logic [IW-1:0]      cur_index_q, cur_index_d;
    logic [IW-1:0]      rom_addr;
    logic [SEQ_LEN-1:0] rom_data;
    logic               loop_ok;

    // The ROM is only consulted when loading, so a looping pass re-reads the latched index.
    assign rom_addr = (state_q == IDLE) ? index : cur_index_q;

    seq_rom #(
        .SEQ_LEN (SEQ_LEN),
        .NUM_SEQ (NUM_SEQ),
        .TABLE   (SEQ_TABLE)
    ) u_rom (
        .addr (rom_addr),
        .data (rom_data)
    );

`ifdef SEQ_PLAYER_LOOP_EN
    assign loop_ok = loop;
`else
    logic loop_unused;
    assign loop_unused = loop;
    assign loop_ok     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            cur_index_q <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            cur_index_q <= cur_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        cur_index_d = cur_index_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = PLAY;
                    cur_index_d = index;
                    shreg_d     = rom_data;
                    tick_d      = '0;
                    bit_d       = '0;
                end
            end
            PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (loop_ok) begin
                            shreg_d = rom_data;
                        end else begin
                            shreg_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = {shreg_q[SEQ_LEN-2:0], 1'b0};
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == PLAY);
    assign done      = (state_q == DONE);
    assign bit_out   = busy & shreg_q[SEQ_LEN-1];
    assign cur_index = cur_index_q;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: default configuration plus a 4-bit/2-entry/TICK_DIV=1 copy.
// Expectations follow SEQ_PLAYER_LOOP_EN when the bench is built with it.
module tb_seq_player;

    localparam int PASS    = 32;
    localparam int MAX_CYC = 4*PASS + 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] index = '0;
    logic       loop = 1'b0;
    logic       bit_out, busy, done;
    logic [2:0] cur_index;

    logic       s_start = 1'b0;
    logic       s_index = 1'b0;
    logic       s_loop = 1'b0;
    logic       s_bit, s_busy, s_done;
    logic       s_cur_index;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_player #(
        .SEQ_LEN  (8),
        .NUM_SEQ  (8),
        .TICK_DIV (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .index     (index),
        .loop      (loop),
        .bit_out   (bit_out),
        .busy      (busy),
        .done      (done),
        .cur_index (cur_index)
    );

    seq_player #(
        .SEQ_LEN   (4),
        .NUM_SEQ   (2),
        .TICK_DIV  (1),
        .SEQ_TABLE ({4'b0110, 4'b1101})
    ) u_small (
        .clk       (clk),
        .rst       (rst),
        .start     (s_start),
        .index     (s_index),
        .loop      (s_loop),
        .bit_out   (s_bit),
        .busy      (s_busy),
        .done      (s_done),
        .cur_index (s_cur_index)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following rising edge (end of cycle 0).
    task automatic play(input int idx, input int restart_at, input int restart_idx,
                        input int abort_at, input int loop_passes,
                        output int busy_n, output int done_n, output int done_at,
                        output int first_busy, output int stray_n, output logic [127:0] stream);
        busy_n = 0; done_n = 0; done_at = 0; first_busy = 0; stray_n = 0; stream = '0;
        start = 1'b1;
        index = 3'(idx);
        loop  = (loop_passes > 0);
        for (int c = 1; c <= MAX_CYC; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_bit_out", bit_out, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_cur_index", cur_index, 0);
                repeat (3) begin
                    @(negedge clk);
                    if (done) done_n++;
                    if (busy) busy_n++;
                end
                start = 1'b0;
                loop  = 1'b0;
                return;
            end
            start = (c == restart_at);
            if (c == restart_at) index = 3'(restart_idx);
            if (busy) begin
                busy_n++;
                if (first_busy == 0) first_busy = c;
                stream = {stream[126:0], bit_out};
                if (cur_index != 3'(idx)) stray_n++;
            end else if (bit_out) begin
                stray_n++;
            end
            if (done) begin
                done_n++;
                done_at = c;
            end
            loop = (c <= loop_passes*PASS);
            if (done_at != 0 && c >= done_at + 2) break;
        end
        loop = 1'b0;
    endtask

    task automatic small_play(input logic idx, output int busy_n, output int done_at,
                              output logic [3:0] stream);
        busy_n = 0; done_at = 0; stream = '0;
        s_start = 1'b1;
        s_index = idx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            s_start = 1'b0;
            if (s_busy) begin
                busy_n++;
                stream = {stream[2:0], s_bit};
            end
            if (s_done && done_at == 0) done_at = c;
        end
    endtask

    int bn, dn, da, fb, sn;
    logic [127:0] st;
    logic [3:0]   sst;

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_bit_out", bit_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cur_index", cur_index, 0);
        chk("rst_small_busy", s_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        play(0, 0, 0, 0, 0, bn, dn, da, fb, sn, st);
        chk("idx0_stream", st, 128'hFFFF0FFF);
        chk("idx0_busy_cycles", bn, PASS);
        chk("idx0_first_busy", fb, 1);
        chk("idx0_done_cycle", da, 33);
        chk("idx0_done_count", dn, 1);
        chk("idx0_stray", sn, 0);
        chk("idx0_idle_cur_index", cur_index, 0);
        chk("idx0_idle_busy", busy, 0);

        play(1, 0, 0, 0, 0, bn, dn, da, fb, sn, st);
        chk("idx1_stream", st, 128'h0000000F);
        chk("idx1_busy_cycles", bn, PASS);
        chk("idx1_done_cycle", da, 33);
        chk("idx1_idle_cur_index", cur_index, 1);

        play(3, 10, 5, 0, 0, bn, dn, da, fb, sn, st);
        chk("restart_stream", st, 128'h0F0F0F0F);
        chk("restart_busy_cycles", bn, PASS);
        chk("restart_done_count", dn, 1);
        chk("restart_stray", sn, 0);
        chk("restart_cur_index", cur_index, 3);

        play(6, 0, 0, 13, 0, bn, dn, da, fb, sn, st);
        chk("abort_busy_cycles", bn, 12);
        chk("abort_no_done", dn, 0);
        rst = 1'b0;
        play(2, 0, 0, 0, 0, bn, dn, da, fb, sn, st);
        chk("post_rst_stream", st, 128'hF00F0F0F);
        chk("post_rst_first_busy", fb, 1);
        chk("post_rst_busy_cycles", bn, PASS);
        chk("post_rst_done_cycle", da, 33);

        play(4, 0, 0, 0, 2, bn, dn, da, fb, sn, st);
`ifdef SEQ_PLAYER_LOOP_EN
        chk("loop_stream", st, 128'hF0F0F0FF_F0F0F0FF_F0F0F0FF);
        chk("loop_busy_cycles", bn, 3*PASS);
        chk("loop_done_count", dn, 1);
        chk("loop_done_cycle", da, 97);
`else
        chk("noloop_stream", st, 128'hF0F0F0FF);
        chk("noloop_busy_cycles", bn, PASS);
        chk("noloop_done_count", dn, 1);
        chk("noloop_done_cycle", da, 33);
`endif
        chk("loop_stray", sn, 0);
        chk("loop_cur_index", cur_index, 4);

        small_play(1'b0, bn, da, sst);
        chk("small0_stream", sst, 4'b1101);
        chk("small0_busy_cycles", bn, 4);
        chk("small0_done_cycle", da, 5);
        small_play(1'b1, bn, da, sst);
        chk("small1_stream", sst, 4'b0110);
        chk("small1_busy_cycles", bn, 4);
        chk("small1_cur_index", s_cur_index, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
